// File: rtl/branch_imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_imm_encoder_pkg
// Desc     : Shared constants and result type for branch immediate encode/decode.
// Revision : 1.0 - initial release
// ============================================================================
package branch_imm_encoder_pkg;

    localparam int IMM24_W          = 24;
    localparam int WORD_SHIFT       = 2;
    localparam int PC_AHEAD_DEFAULT = 8;

    // Bit positions inside the packed error vector
    localparam int ERR_MIS_BIT = 0;
    localparam int ERR_RNG_BIT = 1;
    localparam int ERR_W       = 2;

    typedef struct packed {
        logic [IMM24_W-1:0] imm24;
        logic [ERR_W-1:0]   err;
    } enc_result_t;

endpackage
`default_nettype wire

// File: rtl/branch_imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_imm_encoder_if
// Desc     : Request/response bundle for the branch immediate encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_imm_encoder_if #(
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        pc;
    logic [31:0]        target;
    logic               out_valid;
    logic               out_ready;
    logic [23:0]        imm24;
    logic               err_misaligned;
    logic               err_range;
    logic [COUNT_W-1:0] err_count;

    modport master (
        output in_valid, pc, target, out_ready,
        input  in_ready, out_valid, imm24, err_misaligned, err_range, err_count
    );

    modport slave (
        input  in_valid, pc, target, out_ready,
        output in_ready, out_valid, imm24, err_misaligned, err_range, err_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_imm_check.sv
`default_nettype none
// ============================================================================
// Module   : branch_imm_check
// Desc     : Turns a byte displacement into a 24-bit word offset with error flags.
// Revision : 1.0 - initial release
// ============================================================================
module branch_imm_check
    import branch_imm_encoder_pkg::*;
(
    input  wire logic [31:0]        i_diff,
    output logic      [IMM24_W-1:0] o_imm24,
    output logic                    o_mis,
    output logic                    o_rng
);
    logic w_mis;
    logic w_fits;

    assign w_mis  = |i_diff[WORD_SHIFT-1:0];
    // Offset fits when every bit above the immediate's sign bit copies it
    assign w_fits = (&i_diff[31:IMM24_W+WORD_SHIFT-1]) | ~(|i_diff[31:IMM24_W+WORD_SHIFT-1]);

    assign o_mis   = w_mis;
    assign o_rng   = ~w_fits;
    assign o_imm24 = (w_mis | ~w_fits) ? '0 : i_diff[IMM24_W+WORD_SHIFT-1:WORD_SHIFT];
endmodule
`default_nettype wire

// File: rtl/branch_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : branch_imm_encoder
// Desc     : Two-stage valid/ready pipeline encoding a branch target as imm24.
// Revision : 1.0 - initial release
// ============================================================================
module branch_imm_encoder
    import branch_imm_encoder_pkg::*;
#(
    parameter int PC_AHEAD = PC_AHEAD_DEFAULT,
    parameter int COUNT_W  = 8
)(
    input  wire logic             clk,
    input  wire logic             rst,
    branch_imm_encoder_if.slave   bus
);
    localparam logic [COUNT_W-1:0] c_count_max = '1;

    logic               r_s1_valid;
    logic [31:0]        r_s1_diff;
    logic               r_s2_valid;
    enc_result_t        r_s2_res;
    logic [COUNT_W-1:0] r_err_count;

    logic               w_s1_adv;
    logic               w_s2_adv;
    logic               w_out_xfer;
    enc_result_t        w_chk_res;
    logic               w_chk_mis;
    logic               w_chk_rng;

    assign w_s2_adv   = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign w_out_xfer = r_s2_valid & bus.out_ready;

    branch_imm_check u_check (
        .i_diff  (r_s1_diff),
        .o_imm24 (w_chk_res.imm24),
        .o_mis   (w_chk_mis),
        .o_rng   (w_chk_rng)
    );

    always_comb begin
        w_chk_res.err              = '0;
        w_chk_res.err[ERR_MIS_BIT] = w_chk_mis;
        w_chk_res.err[ERR_RNG_BIT] = w_chk_rng;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_diff <= bus.target - (bus.pc + 32'(PC_AHEAD));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= w_chk_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_out_xfer && (|r_s2_res.err) && (r_err_count != c_count_max)) begin
            r_err_count <= r_err_count + COUNT_W'(1);
        end
    end

    assign bus.in_ready       = w_s1_adv;
    assign bus.out_valid      = r_s2_valid;
    assign bus.imm24          = r_s2_res.imm24;
    assign bus.err_misaligned = r_s2_res.err[ERR_MIS_BIT];
    assign bus.err_range      = r_s2_res.err[ERR_RNG_BIT];
    assign bus.err_count      = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_imm_encoder
// Desc     : Directed scoreboard bench for branch_imm_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_imm_encoder;
    typedef struct packed {
        logic [23:0] imm;
        logic        mis;
        logic        rng;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   exp_cnt = 0;
    exp_t sb[$];

    branch_imm_encoder_if #(.COUNT_W(8)) bus ();

    branch_imm_encoder #(.PC_AHEAD(8), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: signed word offset must lie in [-2^23, 2^23-1]
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] tgt);
        exp_t        e;
        logic [31:0] d;
        longint      off;
        d     = tgt - pc - 32'd8;
        off   = longint'($signed(d)) >>> 2;
        e.mis = (d[1:0] != 2'b00);
        e.rng = (off > 64'sd8388607) || (off < -64'sd8388608);
        e.imm = (e.mis || e.rng) ? 24'h0 : off[23:0];
        return e;
    endfunction

    // Output-side scoreboard: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            check("err_count", 32'(bus.err_count), 32'(exp_cnt));
            if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    check("imm24", {8'h0, bus.imm24}, {8'h0, e.imm});
                    check("err_misaligned", 32'(bus.err_misaligned), 32'(e.mis));
                    check("err_range", 32'(bus.err_range), 32'(e.rng));
                    if ((e.mis || e.rng) && exp_cnt != 255) exp_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] tgt);
        logic acc;
        bus.in_valid = 1'b1;
        bus.pc       = pc;
        bus.target   = tgt;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back(model(pc, tgt));
                #1;
                return;
            end
            #1;
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   base;
        exp_t ea;
        bus.in_valid  = 1'b0;
        bus.pc        = '0;
        bus.target    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_imm24", {8'h0, bus.imm24}, 32'h0);
        check("reset_flags", {30'h0, bus.err_misaligned, bus.err_range}, 32'h0);
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, visible after edge N+1
        send(32'h100, 32'h108);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_imm24", {8'h0, bus.imm24}, 32'h0);
        idle(2);

        // Directed encodings including both range edges, back to back
        send(32'h1000, 32'h0FF8);
        send(32'h0,    32'h0200_0004);
        send(32'h0,    32'h0200_0008);
        send(32'h10,   32'hFE00_0018);
        send(32'h10,   32'hFE00_0014);
        send(32'h100,  32'h10A);
        send(32'h0,    32'h2000_000A);
        idle(4);
        check("sb_empty_directed", 32'(sb.size()), 32'd0);
        check("err_count_directed", 32'(bus.err_count), 32'd4);

        // Backpressure: two accepts fill the pipe, then it stalls
        bus.out_ready = 1'b0;
        ea = model(32'h2000, 32'h3000);
        send(32'h2000, 32'h3000);
        send(32'h2004, 32'h2FF0);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_imm24", {8'h0, bus.imm24}, {8'h0, ea.imm});
            @(posedge clk);
            #1;
        end
        base = pops;
        bus.out_ready = 1'b1;
        send(32'h2008, 32'h2008);
        send(32'h200C, 32'h200E);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("drain_count", 32'(pops - base), 32'd4);
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset with two results in flight
        bus.out_ready = 1'b0;
        send(32'h0, 32'h0200_0008);
        send(32'h0, 32'h0000_0003);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Saturation: 300 misaligned results
        for (int i = 0; i < 300; i++) begin
            send(32'h0, 32'(i * 4 + 1));
        end
        idle(4);
        check("sat_err_count", 32'(bus.err_count), 32'd255);
        check("sb_empty_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
